bcd_seq_ctrl: RTL and testbench

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

---
 rtl/bcd_seq_ctrl_if.sv | 24 ++
 rtl/bcd_seq_ctrl.sv | 111 +++++++++++
 tb/tb_bcd_seq_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bcd_seq_ctrl_if.sv
// Handshake and result bundle between the control unit and the BCD converter.
// The master drives the request and ALU value; the slave returns status and digits.
interface bcd_seq_ctrl_if;
    logic        start;
    logic        out;
    logic [31:0] saidaUla;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  mil;
    logic [3:0]  cent;
    logic [3:0]  dez;
    logic [3:0]  uni;

    modport master (
        output start, out, saidaUla,
        input  busy, done, ovf, mil, cent, dez, uni
    );

    modport slave (
        input  start, out, saidaUla,
        output busy, done, ovf, mil, cent, dez, uni
    );
endinterface

// File: rtl/bcd_seq_ctrl.sv
// Sequential double-dabble binary-to-BCD converter with overflow clamp at 9999.
// Result and done appear 16 edges after acceptance; start is ignored while busy (no queuing).
module bcd_seq_ctrl #(
    parameter int NDIG = 4
) (
    input  logic         clock,
    input  logic         reset,
    bcd_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state, state_nxt;
    logic [31:0]         hold;
    logic [4*NDIG-1:0]   scratch;
    logic [4*NDIG-1:0]   adj;
    logic [4*NDIG-1:0]   scratch_nxt;
    logic [3:0]          cnt;
    logic [15:0]         hold_lo;
    logic                ovf_q;
    logic [3:0]          mil_q, cent_q, dez_q, uni_q;
    logic                busy_c, done_c;

    assign hold_lo = hold[15:0];

    // Add-3 on every digit >= 5, then shift the whole chain left taking the next source bit.
    always_comb begin
        adj = '0;
        for (int i = 0; i < NDIG; i++) begin
            adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3
                                                         : scratch[4*i +: 4];
        end
        scratch_nxt = {adj[4*NDIG-2:0], hold_lo[cnt]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && bus.out) state_nxt = CONV;
            CONV:    if (cnt == 4'd0)          state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state == CONV) || (state == DONE);
        done_c = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold    <= '0;
            scratch <= '0;
            cnt     <= '0;
            ovf_q   <= 1'b0;
            mil_q   <= '0;
            cent_q  <= '0;
            dez_q   <= '0;
            uni_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && bus.out) begin
                        hold    <= bus.saidaUla;
                        scratch <= '0;
                        cnt     <= 4'd15;
                    end else if (bus.start) begin
                        ovf_q  <= 1'b0;
                        mil_q  <= '0;
                        cent_q <= '0;
                        dez_q  <= '0;
                        uni_q  <= '0;
                    end
                end
                CONV: begin
                    scratch <= scratch_nxt;
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (hold > 32'd9999) begin
                        // Scratch is meaningless once the value is out of range; clamp instead.
                        ovf_q  <= 1'b1;
                        mil_q  <= 4'd9;
                        cent_q <= 4'd9;
                        dez_q  <= 4'd9;
                        uni_q  <= 4'd9;
                    end else begin
                        ovf_q  <= 1'b0;
                        mil_q  <= scratch_nxt[15:12];
                        cent_q <= scratch_nxt[11:8];
                        dez_q  <= scratch_nxt[7:4];
                        uni_q  <= scratch_nxt[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.ovf  = ovf_q;
    assign bus.mil  = mil_q;
    assign bus.cent = cent_q;
    assign bus.dez  = dez_q;
    assign bus.uni  = uni_q;
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Bench for bcd_seq_ctrl: directed scenarios plus random traffic against a latency/arithmetic model.
module tb_bcd_seq_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bcd_seq_ctrl_if bus();

    bcd_seq_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          ntot  = 0;
    int          npass = 0;
    // Model: cycles elapsed since acceptance (0 = idle), pending value, expected visible outputs.
    int          phase = 0;
    logic [31:0] pend  = '0;
    logic [15:0] edig  = '0;
    logic        eovf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input logic [31:0] v);
        int n;
        if (v > 32'd9999) return 16'h9999;
        n = int'(v);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic model_step(input logic st, input logic o, input logic [31:0] v);
        if (reset) begin
            phase = 0; edig = '0; eovf = 1'b0;
        end else if (phase == 0) begin
            if (st && o) begin
                phase = 1; pend = v;
            end else if (st) begin
                edig = '0; eovf = 1'b0;
            end
        end else begin
            phase++;
            if (phase == 17) begin
                edig = to_bcd(pend);
                eovf = (pend > 32'd9999);
            end
            if (phase == 18) phase = 0;
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":busy"}, {31'b0, bus.busy}, {31'b0, (phase != 0)});
        chk({ctx, ":done"}, {31'b0, bus.done}, {31'b0, (phase == 17)});
        chk({ctx, ":ovf"},  {31'b0, bus.ovf},  {31'b0, eovf});
        chk({ctx, ":digits"}, {16'b0, bus.mil, bus.cent, bus.dez, bus.uni}, {16'b0, edig});
    endtask

    // Called at a falling edge: drive, advance one rising edge, then check at the next falling edge.
    task automatic cycle(input string ctx, input logic st, input logic o, input logic [31:0] v);
        bus.start = st; bus.out = o; bus.saidaUla = v;
        @(posedge clock);
        model_step(st, o, v);
        @(negedge clock);
        check_all(ctx);
    endtask

    task automatic idle(input string ctx, input int n);
        for (int i = 0; i < n; i++) cycle(ctx, 1'b0, 1'b1, $urandom);
    endtask

    task automatic pulse_reset(input string ctx);
        reset = 1'b1;
        #1;
        phase = 0; edig = '0; eovf = 1'b0;
        check_all({ctx, "_async"});
        cycle({ctx, "_held"}, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 9999));
            1:       return 32'(9990 + $urandom_range(0, 20));
            2:       return $urandom;
            default: return (32'($urandom_range(0, 15)) << 16) | 32'($urandom_range(0, 9999));
        endcase
    endfunction

    initial begin
        bus.start = 1'b0; bus.out = 1'b0; bus.saidaUla = '0;
        @(negedge clock);
        check_all("reset");
        cycle("reset_held", 1'b1, 1'b1, 32'd77);
        reset = 1'b0;

        // 1234 basic conversion
        cycle("c1234", 1'b1, 1'b1, 32'd1234);
        idle("c1234", 18);

        // 0 then 9999 with start held so the second is taken at the earliest legal edge
        cycle("b2b0", 1'b1, 1'b1, 32'd0);
        for (int i = 0; i < 17; i++) cycle("b2b_hold", 1'b1, 1'b1, 32'd55);
        cycle("b2b9999", 1'b1, 1'b1, 32'd9999);
        idle("b2b9999", 18);

        // overflow cases
        cycle("ovf10000", 1'b1, 1'b1, 32'd10000);
        idle("ovf10000", 18);
        cycle("ovf10005", 1'b1, 1'b1, 32'h0001_0005);
        idle("ovf10005", 18);

        // restart attempt during conversion is ignored
        cycle("ign1234", 1'b1, 1'b1, 32'd1234);
        idle("ign1234", 4);
        cycle("ign42", 1'b1, 1'b1, 32'd42);
        idle("ign1234", 14);

        // reset mid-conversion then a fresh conversion of 56, start right as reset drops
        cycle("abort", 1'b1, 1'b1, 32'd1234);
        idle("abort", 7);
        pulse_reset("abort_rst");
        cycle("c56", 1'b1, 1'b1, 32'd56);
        idle("c56", 18);

        // clear with out=0 after a 1234 result
        cycle("clr1234", 1'b1, 1'b1, 32'd1234);
        idle("clr1234", 18);
        cycle("clr", 1'b1, 1'b0, 32'd777);
        idle("clr_after", 2);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset("rnd_rst");
            else cycle("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), rand_val());
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
